// File: rtl/yalu_serial.sv
// Slice-serial 32-bit ALU (AND/OR/ADD/SUB, optional SLT) behind a valid/ready handshake.
// Define YALU_SLT_EN to enable the signed less-than opcode (111).
module yalu_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] z,
  output logic             ex
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, z_q, z_d;
  logic [2:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d, ex_q, ex_d, rsp_valid_q, rsp_valid_d;

  logic [SLICE-1:0]   a_sl_s, b_sl_s, res_sl_s;
  logic [SLICE:0]     sum_s;
  logic [WIDTH-1:0]   final_s;
  logic               sub_s;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign z         = z_q;
  assign ex        = ex_q;

  // Next-state, slice datapath and result capture
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    z_d         = z_q;
    ex_d        = ex_q;
    rsp_valid_d = rsp_valid_q;

    sub_s  = (op_q == OP_SUB) || (op_q == OP_SLT);
    a_sl_s = a_q[int'(cnt_q) * SLICE +: SLICE];
    b_sl_s = sub_s ? ~b_q[int'(cnt_q) * SLICE +: SLICE] : b_q[int'(cnt_q) * SLICE +: SLICE];
    sum_s  = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SLICE{1'b0}}, carry_q};

    case (op_q)
      OP_AND:  res_sl_s = a_sl_s & b_sl_s;
      OP_OR:   res_sl_s = a_sl_s | b_sl_s;
      OP_ADD:  res_sl_s = sum_s[SLICE-1:0];
      OP_SUB:  res_sl_s = sum_s[SLICE-1:0];
`ifdef YALU_SLT_EN
      OP_SLT:  res_sl_s = sum_s[SLICE-1:0];
`endif
      default: res_sl_s = {SLICE{1'b0}};
    endcase

    final_s = acc_q;
    final_s[int'(cnt_q) * SLICE +: SLICE] = res_sl_s;
`ifdef YALU_SLT_EN
    // Signed less-than: difference sign corrected by subtraction overflow
    if (op_q == OP_SLT) begin
      final_s = {{(WIDTH-1){1'b0}},
                 final_s[WIDTH-1] ^ ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (final_s[WIDTH-1] ^ a_q[WIDTH-1]))};
    end else begin
      final_s = final_s;
    end
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = {CNT_W{1'b0}};
          carry_d = (op == OP_SUB) || (op == OP_SLT);
          acc_d   = {WIDTH{1'b0}};
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d[int'(cnt_q) * SLICE +: SLICE] = res_sl_s;
        carry_d = sum_s[SLICE];
        if (cnt_q == CNT_W'(N - 1)) begin
          cnt_d       = {CNT_W{1'b0}};
          z_d         = final_s;
          ex_d        = (final_s == {WIDTH{1'b0}});
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      op_q        <= 3'b000;
      cnt_q       <= {CNT_W{1'b0}};
      carry_q     <= 1'b0;
      acc_q       <= {WIDTH{1'b0}};
      z_q         <= {WIDTH{1'b0}};
      ex_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
      ex_q        <= ex_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_yalu_serial.sv
// Directed and random bench for yalu_serial; expected results queue in a scoreboard.
module tb_yalu_serial;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, rsp_valid, rsp_ready, ex;
  logic [31:0] a, b, z;
  logic [2:0]  op;

  int passed = 0;
  int total  = 0;
  logic [32:0] sb_q[$];

  yalu_serial dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .a(a), .b(b), .op(op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .z(z), .ex(ex)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] model(logic [31:0] ma, logic [31:0] mb, logic [2:0] mop);
    logic [31:0] r;
    case (mop)
      3'b000:  r = ma & mb;
      3'b001:  r = ma | mb;
      3'b010:  r = ma + mb;
      3'b110:  r = ma - mb;
`ifdef YALU_SLT_EN
      3'b111:  r = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
`endif
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, stall the response for 'stall' cycles, then consume and score it.
  task automatic do_txn(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                        input int stall, input string tag);
    int lat;
    logic [32:0] held, exp;
    lat = 0;
    while (!req_ready && lat < 20) begin
      step();
      lat++;
    end
    if (lat >= 20) check({tag, "_req_ready_timeout"}, 64'(req_ready), 64'd1);
    a = ta; b = tb; op = top; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    sb_q.push_back(model(ta, tb, top));
    lat = 0;
    while (lat < 20) begin
      step();
      lat++;
      if (rsp_valid) break;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    held = {ex, z};
    for (int i = 0; i < stall; i++) begin
      if (i == 2) req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      check({tag, "_hold_out"}, 64'({rsp_valid, req_ready, ex, z}), 64'({2'b10, held}));
    end
    rsp_ready = 1'b1;
    exp = sb_q.pop_front();
    check({tag, "_result"}, 64'({ex, z}), 64'(exp));
    step();
    rsp_ready = 1'b0;
    check({tag, "_to_idle"}, 64'({rsp_valid, req_ready}), 64'b01);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; a = 32'd0; b = 32'd0; op = 3'b000;
    step(); step();
    rst = 1'b0;
    check("reset_state", 64'({req_ready, rsp_valid, ex, z}), 64'({2'b10, 1'b0, 32'd0}));

    // Reset while BUSY discards the transaction
    a = 32'd7; b = 32'd9; op = 3'b010; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy_state", 64'({req_ready, rsp_valid, ex, z}), 64'({2'b10, 1'b0, 32'd0}));
    for (int i = 0; i < 6; i++) step();
    check("rst_busy_no_rsp", 64'({req_ready, rsp_valid}), 64'b10);
    do_txn(32'd1, 32'd1, 3'b010, 0, "add_1_1");

    do_txn(32'h0000_00FF, 32'h0000_0001, 3'b010, 0, "add_carry");
    do_txn(32'd5, 32'd5, 3'b110, 1, "sub_eq");
    do_txn(32'hFFFF_FFFF, 32'd1, 3'b010, 0, "add_wrap");
    do_txn(32'd3, 32'd5, 3'b110, 0, "sub_neg");
    do_txn(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 0, "and");
    do_txn(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 0, "or");
    do_txn(32'hDEAD_BEEF, 32'h1234_5678, 3'b011, 0, "unsup_011");
    do_txn(32'hDEAD_BEEF, 32'h1234_5678, 3'b101, 0, "unsup_101");

    // Backpressure with an ignored request pulse during DONE
    do_txn(32'h1234_5678, 32'h1111_1111, 3'b010, 5, "backpressure");
    for (int i = 0; i < 6; i++) step();
    check("bp_pulse_ignored", 64'({req_ready, rsp_valid}), 64'b10);

    do_txn(32'h8000_0000, 32'd1, 3'b111, 0, "slt_neg_pos");
    do_txn(32'd1, 32'h8000_0000, 3'b111, 0, "slt_pos_neg");
    do_txn(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b111, 0, "slt_max_m1");

    for (int n = 0; n < 1000; n++) begin
      do_txn($urandom, $urandom, 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), "random");
    end
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/yalu_serial.md
# yalu_serial

Multi-cycle, slice-serial implementation of the 32-bit ALU operation set (AND, OR, ADD, SUB, optional SLT), wrapped in a request/response handshake. It is the responder to an operand issuer such as a datapath sequencer or stimulus engine: it accepts one operation, processes SLICE bits per clock, and holds the result until the consumer takes it. Results are bit-identical to the combinational ALU for every supported opcode, so both can be checked against the same expected-value model.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of SLICE
- SLICE, 8, bits processed per BUSY cycle; N = WIDTH/SLICE BUSY cycles per operation
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  issuer presents a, b, op
- req_ready  out  1  block can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (only with YALU_SLT_EN)
- rsp_valid  out  1  z/ex valid
- rsp_ready  in  1  consumer takes the result
- z  out  WIDTH  result
- ex  out  1  zero flag: 1 iff z == 0

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: req_ready=1. On req_valid: latch a, b, op; slice counter cnt=0; carry=1 when op is 110 or 111, else 0; go BUSY. Inputs are sampled only at the accept edge and may change afterwards.
- BUSY: req_ready=0. Each edge processes bits [cnt*SLICE +: SLICE]: AND/OR bitwise; ADD a+b+carry; SUB/SLT a+~b+carry; the slice carry-out becomes the next carry. cnt increments; after slice N-1, go DONE.
- DONE: rsp_valid=1, z/ex held stable. On rsp_ready go IDLE. No new request is accepted in the same cycle as rsp_ready; req_ready rises the following cycle.
- Arithmetic wraps modulo 2^WIDTH; carry-out and overflow are not reported.
- Opcodes 011, 100, 101 (and 111 without YALU_SLT_EN): full N-cycle sequence; z=0, ex=1.
- ex is computed from the final z when DONE is entered and is never taken from a partial result.
- rst has priority in every state: state IDLE, cnt=0, carry=0, z=0, ex=0, rsp_valid=0. A transaction in flight is discarded without a response. req_ready=1 in the cycle after reset.

## Timing
- Accept at edge t0 (req_valid & req_ready). BUSY during edges t1..tN. rsp_valid is high after edge tN, i.e. N cycles after accept (4 for defaults).
- The earliest next accept is one cycle after the rsp_ready edge. Minimum issue interval is N+2 cycles.
- rsp_valid, z and ex are registered outputs. req_ready is a decode of state only.
- In IDLE, z/ex keep the last result; they are meaningful only while rsp_valid=1.
- rsp_ready held high: DONE lasts exactly one cycle.

## Configuration
- YALU_SLT_EN defined: op 111 computes the signed compare a<b as the final-sum MSB XOR signed overflow. z = {WIDTH-1 zeros, lt}, and ex follows z.
- Not defined: op 111 is treated as unsupported (z=0, ex=1). No SLT overflow logic is present. Timing is identical in both builds.

## Test plan
- Reset mid-BUSY: accept ADD, assert rst at the second BUSY edge -> after reset rsp_valid=0, z=0, ex=0, req_ready=1. The next ADD 1+1 returns z=2.
- Arithmetic carry across slices: ADD a=0x000000FF, b=0x00000001 -> z=0x00000100, ex=0, with rsp_valid exactly 4 cycles after accept. SUB a=5, b=5 -> z=0, ex=1. ADD 0xFFFFFFFF+1 -> z=0, ex=1 (wrap).
- Logic: AND a=0xF0F0F0F0, b=0xFF00FF00 -> z=0xF000F000. OR with the same operands -> z=0xFFF0FFF0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> z/ex stable, req_ready=0 throughout, and a req_valid pulse during DONE is ignored. Raise rsp_ready -> IDLE next cycle.
- SLT (YALU_SLT_EN): a=0x80000000, b=1 -> z=1. a=1, b=0x80000000 -> z=0, ex=1. a=0x7FFFFFFF, b=0xFFFFFFFF -> z=0. Without the macro: op 111 -> z=0, ex=1.
- Random regression: 1000 random a/b/op with random rsp_ready stalls -> every response matches the expected model for its op (unsupported -> 0), with no lost or duplicated responses.
